// File: rtl/uart_rx.sv
// Purpose     : UART serial receiver, 16x oversampled; frame = start(0), N_BITS_DATA data LSB first, parity, stop(1).
// Latency     : rx_done pulses mid stop bit, about 10.5 bit periods (+3 clocks) after the start-bit falling edge on the pin.
// Backpressure: none; the line cannot be stalled. Each byte is presented with a one-clock rx_done pulse and held until the next frame.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   s_ticks      oversampling tick, one-clock pulse, 16 per bit period
//   rx_data_in   serial line, asynchronous to clock, idles high
//   rx_data_out  last received byte
//   rx_done      one-clock pulse when a frame completes
//   frame_err    stop bit sampled 0 in the last frame
//   parity_err   even-parity mismatch in the last frame (only when UART_RX_PARITY_CHECK_EN is defined, else 0)
//
// Build option: `define UART_RX_PARITY_CHECK_EN to check the parity slot against even parity of the data.

module uart_rx #(
    parameter int N_BITS_DATA  = 8,
    parameter int N_CONT_TICKS = 4,
    parameter int N_BITS_STATE = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   s_ticks,
    input  logic                   rx_data_in,
    output logic [N_BITS_DATA-1:0] rx_data_out,
    output logic                   rx_done,
    output logic                   frame_err,
    output logic                   parity_err
);

    localparam logic [N_BITS_STATE-1:0] ST_IDLE   = N_BITS_STATE'(5'b00001);
    localparam logic [N_BITS_STATE-1:0] ST_START  = N_BITS_STATE'(5'b00010);
    localparam logic [N_BITS_STATE-1:0] ST_DATA   = N_BITS_STATE'(5'b00100);
    localparam logic [N_BITS_STATE-1:0] ST_PARITY = N_BITS_STATE'(5'b01000);
    localparam logic [N_BITS_STATE-1:0] ST_STOP   = N_BITS_STATE'(5'b10000);

    localparam logic [N_CONT_TICKS-1:0] TICK_MID  = N_CONT_TICKS'(7);
    localparam logic [N_CONT_TICKS-1:0] TICK_LAST = N_CONT_TICKS'(15);
    localparam logic [N_CONT_TICKS-1:0] BIT_LAST  = N_CONT_TICKS'(N_BITS_DATA - 1);
    localparam logic [N_CONT_TICKS-1:0] CNT_ONE   = N_CONT_TICKS'(1);

    // Two-flop synchronizer; reset to the idle (high) line level so reset
    // release never looks like a start bit.
    logic rx_meta_q;
    logic rx_s_q;

    logic [N_BITS_STATE-1:0] state_q, state_d;
    logic                    armed_q, armed_d;
    logic [N_CONT_TICKS-1:0] tick_q,  tick_d;
    logic [N_CONT_TICKS-1:0] bit_q,   bit_d;
    logic [N_BITS_DATA-1:0]  shift_q, shift_d;
    logic [N_BITS_DATA-1:0]  data_q,  data_d;
    logic                    done_q,  done_d;
    logic                    ferr_q,  ferr_d;
    logic                    perr_q,  perr_d;
`ifdef UART_RX_PARITY_CHECK_EN
    logic                    parity_q, parity_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_data_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
`ifdef UART_RX_PARITY_CHECK_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // armed is only set by seeing the line high, so a line held
                // low after a bad stop bit (break) cannot start a new frame.
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end

            ST_START: begin
                if (s_ticks) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s_q) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = ST_DATA;
                        end else begin
                            // Glitch shorter than half a bit: drop it silently.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + CNT_ONE;
                    end
                end
            end

            ST_DATA: begin
                if (s_ticks) begin
                    if (tick_q == TICK_LAST) begin
                        // LSB arrives first: shifting right from the MSB
                        // leaves the first bit at position 0.
                        shift_d = {rx_s_q, shift_q[N_BITS_DATA-1:1]};
                        bit_d   = bit_q + CNT_ONE;
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_PARITY;
                        end
                    end else begin
                        tick_d = tick_q + CNT_ONE;
                    end
                end
            end

            ST_PARITY: begin
                if (s_ticks) begin
                    if (tick_q == TICK_LAST) begin
`ifdef UART_RX_PARITY_CHECK_EN
                        parity_d = rx_s_q;
`endif
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + CNT_ONE;
                    end
                end
            end

            ST_STOP: begin
                if (s_ticks) begin
                    if (tick_q == TICK_LAST) begin
                        data_d  = shift_q;
                        ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_CHECK_EN
                        perr_d  = (^shift_q) ^ parity_q;
`else
                        perr_d  = 1'b0;
`endif
                        done_d  = 1'b1;
                        tick_d  = '0;
                        // Leaving mid stop bit lets the next start edge be
                        // caught immediately for back-to-back frames.
                        state_d = ST_IDLE;
                        armed_d = rx_s_q;
                    end else begin
                        tick_d = tick_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b0;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign rx_data_out = data_q;
    assign rx_done     = done_q;
    assign frame_err   = ferr_q;
    assign parity_err  = perr_q;

endmodule
